// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes,
// FSM states and the default operand width.
package mdu_pkg;

    localparam int MDU_XLEN = 32;

    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_muldiv(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage to mul/div unit bus: op request in, HI/LO and pipeline status out.
interface mdu_ctrl_if import mdu_pkg::*; #(
    parameter int XLEN = MDU_XLEN
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic            flush;
    logic            rd_hilo;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            busy;
    logic            done;
    logic            stall;

    modport master (
        output start, op, x, y, flush, rd_hilo,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, x, y, flush, rd_hilo,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not borrow.
module mdu_divstep import mdu_pkg::*; #(
    parameter int XLEN = MDU_XLEN
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN:0]   rem_o,
    output logic            q_o
);
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = {1'b0, shifted} - {2'b00, div_i};
        q_o     = ~diff[XLEN+1];
        rem_o   = q_o ? diff[XLEN:0] : shifted;
    end
endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide sequencer owning the architectural HI/LO registers.
//   state  | meaning
//   S_IDLE | waiting for an op; MTHI/MTLO complete here in one cycle
//   S_RUN  | one shift-add or restoring-divide iteration per edge, XLEN edges
//   S_FIX  | sign correction and HI/LO write, done pulse follows
module mdu_ctrl import mdu_pkg::*; #(
    parameter int              XLEN    = MDU_XLEN,
    parameter logic [XLEN-1:0] DIV0_LO = {XLEN{1'b1}}
) (
    input logic        clk,
    input logic        rst_n,
    mdu_ctrl_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam int AW = 2*XLEN + 1;

    mdu_state_e      state_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   acc_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] x_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic            is_div_q;
    logic            neg_q;
    logic            rneg_q;
    logic            div0_q;
    logic            busy_q;
    logic            done_q;

    mdu_op_e         op_in;
    logic            sgn;
    logic            xs;
    logic            ys;
    logic            accept;
    logic [XLEN-1:0] x_mag;
    logic [XLEN-1:0] y_mag;
    logic [XLEN:0]   mul_sum;
    logic [AW-1:0]   mul_next;
    logic [AW-1:0]   div_next;
    logic [XLEN:0]   rem_nx;
    logic            q_bit;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    always_comb begin
        op_in  = mdu_op_e'(bus.op);
        sgn    = op_is_signed(op_in);
        xs     = sgn & bus.x[XLEN-1];
        ys     = sgn & bus.y[XLEN-1];
        x_mag  = xs ? -bus.x : bus.x;
        y_mag  = ys ? -bus.y : bus.y;
        accept = bus.start & ~bus.flush & (state_q == S_IDLE);
    end

    mdu_divstep #(.XLEN(XLEN)) u_divstep (
        .rem_i (acc_q[2*XLEN-1:XLEN]),
        .bit_i (acc_q[XLEN-1]),
        .div_i (b_q),
        .rem_o (rem_nx),
        .q_o   (q_bit)
    );

    // Multiply keeps the multiplier in the low half and shifts the product in from the top.
    always_comb begin
        mul_sum  = acc_q[AW-1:XLEN] + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {1'b0, mul_sum, acc_q[XLEN-1:1]};
        div_next = {rem_nx, acc_q[XLEN-2:0], q_bit};
        prod_fix = neg_q  ? -acc_q[2*XLEN-1:0]    : acc_q[2*XLEN-1:0];
        quo_fix  = neg_q  ? -acc_q[XLEN-1:0]      : acc_q[XLEN-1:0];
        rem_fix  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            x_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (op_is_muldiv(op_in)) begin
                            state_q  <= S_RUN;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            is_div_q <= op_is_div(op_in);
                            neg_q    <= xs ^ ys;
                            rneg_q   <= xs;
                            div0_q   <= (bus.y == '0);
                            x_q      <= bus.x;
                            if (op_is_div(op_in)) begin
                                acc_q <= {{(XLEN+1){1'b0}}, x_mag};
                                b_q   <= y_mag;
                            end else begin
                                acc_q <= {{(XLEN+1){1'b0}}, y_mag};
                                b_q   <= x_mag;
                            end
                        end else if (op_in == MDU_MTHI) begin
                            hi_q <= bus.x;
                        end else if (op_in == MDU_MTLO) begin
                            lo_q <= bus.x;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= is_div_q ? div_next : mul_next;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(XLEN-1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    // A squash arriving on the write edge still wins.
                    if (!bus.flush) begin
                        done_q <= 1'b1;
                        if (!is_div_q) begin
                            {hi_q, lo_q} <= prod_fix;
                        end else if (div0_q) begin
                            hi_q <= x_q;
                            lo_q <= DIV0_LO;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.stall = busy_q & (bus.start | bus.rd_hilo);
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed corner cases plus random ops checked
// against an arithmetic reference model.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_ctrl_if #(.XLEN(32)) bus();
    mdu_ctrl #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          run_len  = 0;
    logic        prev_done = 1'b0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic, including the two architectural special cases.
    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      pa;
        longint      pb;
        int          sa;
        int          sb;
        logic [63:0] r;
        r = 64'h0;
        case (op)
            3'd1: begin
                pa = longint'($signed(a));
                pb = longint'($signed(b));
                r  = 64'(pa * pb);
            end
            3'd2: r = {32'h0, a} * {32'h0, b};
            3'd3: begin
                if (b == 32'h0)                              r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    sa = int'(a);
                    sb = int'(b);
                    r  = {32'(sa % sb), 32'(sa / sb)};
                end
            end
            3'd4: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
            end
            default: r = 64'h0;
        endcase
        return r;
    endfunction

    // Monitor: pops an expectation on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) check("stall_rule", 32'(bus.stall), 32'(bus.busy & (bus.start | bus.rd_hilo)));
        if (bus.done === 1'b1) begin
            check("done_width", 32'(prev_done), 32'h0);
            check("busy_len", 32'(run_len), 32'd33);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done_pulse expected=no_pulse t=%0t", $time);
            end else begin
                e = sb_q.pop_front();
                check("sb_hi", bus.hi, e.hi);
                check("sb_lo", bus.lo, e.lo);
                check("done_time", 32'(cyc), 32'(e.due));
            end
        end
        run_len   = (bus.busy === 1'b1) ? run_len + 1 : 0;
        prev_done = bus.done;
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=busy expected=idle t=%0t", $time);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit directed, input logic [63:0] dexp);
        logic [63:0] e;
        wait_idle();
        bus.op    = op;
        bus.x     = a;
        bus.y     = b;
        bus.start = 1'b1;
        if (op >= 3'd1 && op <= 3'd4) begin
            e = directed ? dexp : ref_model(op, a, b);
            sb_q.push_back('{e[63:32], e[31:0], cyc + 34});
            m_hi = e[63:32];
            m_lo = e[31:0];
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        case (op)
            3'd5: begin
                m_hi = a;
                check("mthi_hi", bus.hi, m_hi);
                check("mthi_busy", 32'(bus.busy), 32'h0);
            end
            3'd6: begin
                m_lo = a;
                check("mtlo_lo", bus.lo, m_lo);
                check("mtlo_busy", 32'(bus.busy), 32'h0);
            end
            3'd0, 3'd7: begin
                check("nop_hi", bus.hi, m_hi);
                check("nop_lo", bus.lo, m_lo);
                check("nop_busy", 32'(bus.busy), 32'h0);
            end
            default: check("muldiv_busy", 32'(bus.busy), 32'h1);
        endcase
    endtask

    // Start an op that will be squashed, so no expectation is queued.
    task automatic start_raw(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        bus.op    = op;
        bus.x     = a;
        bus.y     = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] rx;
        logic [31:0] ry;
        int          n;
        bus.start   = 1'b0;
        bus.op      = 3'd0;
        bus.x       = 32'h0;
        bus.y       = 32'h0;
        bus.flush   = 1'b0;
        bus.rd_hilo = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001);
        issue(3'd1, 32'hFFFF_FFFD, 32'd7,         1, 64'hFFFF_FFFF_FFFF_FFEB);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2,         1, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(3'd4, 32'd100,       32'd0,         1, 64'h0000_0064_FFFF_FFFF);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1, 64'h0000_0000_8000_0000);

        // MULT 5*6, MTLO held from cycle 5, MFHI/MFLO from cycle 10.
        issue(3'd1, 32'd5, 32'd6, 1, 64'h0000_0000_0000_001E);
        repeat (4) begin @(posedge clk); #1; end
        bus.op = 3'd6; bus.x = 32'h5A5A; bus.start = 1'b1;
        #1;
        check("stall_mtlo", 32'(bus.stall), 32'h1);
        repeat (5) begin @(posedge clk); #1; end
        bus.rd_hilo = 1'b1;
        #1;
        check("stall_rd", 32'(bus.stall), 32'h1);
        n = 0;
        while (bus.busy !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
        check("stall_release", 32'(bus.stall), 32'h0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.rd_hilo = 1'b0;
        m_lo = 32'h5A5A;
        check("mtlo_after_hi", bus.hi, 32'h0);
        check("mtlo_after_lo", bus.lo, 32'h5A5A);

        // Flush in RUN at cycle 20 of DIVU 50/7.
        issue(3'd5, 32'h11, 32'h0, 0, 64'h0);
        issue(3'd6, 32'h22, 32'h0, 0, 64'h0);
        start_raw(3'd4, 32'd50, 32'd7);
        repeat (19) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'h0);
        check("flush_hi", bus.hi, 32'h11);
        check("flush_lo", bus.lo, 32'h22);
        issue(3'd2, 32'd6, 32'd7, 1, 64'd42);

        // Flush landing on the FIX edge.
        start_raw(3'd3, 32'd1000, 32'd3);
        repeat (32) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("fixflush_busy", 32'(bus.busy), 32'h0);
        check("fixflush_hi", bus.hi, m_hi);
        check("fixflush_lo", bus.lo, m_lo);

        // Flush together with start in IDLE: nothing accepted.
        wait_idle();
        bus.op = 3'd5; bus.x = 32'hDEAD; bus.start = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        check("idleflush_hi", bus.hi, m_hi);
        bus.op = 3'd1; bus.x = 32'd9; bus.y = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        check("idleflush_busy", 32'(bus.busy), 32'h0);

        // Asynchronous reset mid-RUN.
        issue(3'd5, 32'h77, 32'h0, 0, 64'h0);
        issue(3'd6, 32'h88, 32'h0, 0, 64'h0);
        issue(3'd2, $urandom, $urandom, 0, 64'h0);
        repeat (10) begin @(posedge clk); #1; end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("amid_hi", bus.hi, 32'h0);
        check("amid_lo", bus.lo, 32'h0);
        check("amid_busy", 32'(bus.busy), 32'h0);
        sb_q.delete();
        m_hi = 32'h0;
        m_lo = 32'h0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        issue(3'd5, 32'hABCD, 32'h0, 0, 64'h0);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            rx  = $urandom;
            ry  = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'h0;
                1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                2: ry = 32'($urandom_range(1, 15));
                3: ry = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            issue(rop, rx, ry, 0, 64'h0);
        end

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer with architectural HI/LO registers for the pipelined MIPS core.
- Sits beside the EX-stage ALU. It takes MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, runs mul/div iteratively over 32 cycles, and stalls the pipeline while HI/LO are unavailable.
- Replaces the single-cycle combinational mul/div path so the critical path stays at ALU add/shift depth.

Parameters:
- XLEN, 32, operand width; the iteration count equals XLEN.
- DIV0_LO, 32'hFFFF_FFFF, LO value written on divide-by-zero.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  EX-stage op valid this cycle
- op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP)
- x  in  XLEN  rs operand (multiplicand/dividend; MTHI/MTLO source)
- y  in  XLEN  rt operand (multiplier/divisor)
- flush  in  1  abort the in-flight op (branch/exception squash)
- rd_hilo  in  1  EX-stage MFHI/MFLO present
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register
- busy  out  1  mul/div in progress
- done  out  1  one-cycle pulse when HI/LO are updated by mul/div
- stall  out  1  pipeline freeze request

Behaviour:
- Reset (asynchronous, rst_n=0): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, operand/accumulator regs=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, 32 iterations.
  - FIX: busy=1, sign correction, HI/LO write.
  - Transitions: IDLE -> RUN on start with op 1-4 and flush=0. RUN -> FIX when count reaches XLEN-1. FIX -> IDLE unconditionally.
- Latency: start sampled at edge E0. RUN covers edges E1..E32 (one iteration per edge). FIX update happens at E33. hi/lo/done become valid after E33, and busy falls after E33. Total occupancy is 33 cycles. A back-to-back start is accepted at E34 at the earliest (start is sampled in IDLE only).
- done: high exactly one cycle, the cycle following the FIX edge. It is never asserted for MTHI/MTLO.
- Multiply:
  - Shift-add on magnitudes, 64-bit product; {hi,lo} = product.
  - MULT: operands sign-converted to magnitude at E0; the product is negated in FIX if signs differ.
  - MULTU: raw operands.
- Divide:
  - Restoring, one quotient bit per cycle; lo=quotient, hi=remainder.
  - DIV: quotient negated if signs differ; remainder takes the dividend sign.
  - 0x80000000 / -1 gives lo=0x80000000, hi=0 (no trap).
  - y==0 (DIV or DIVU): hi=x (original, unconverted), lo=DIV0_LO. The sequence still takes the full 33 cycles.
- MTHI/MTLO:
  - In IDLE with start=1, write x into hi/lo at that edge; single cycle, busy stays 0.
  - While busy: not accepted; the stall holds the instruction.
- stall = busy & (start | rd_hilo), combinational. When stalled, EX holds its inputs and the block ignores start.
- flush:
  - During RUN/FIX: return to IDLE on the next edge; hi/lo unchanged; no done pulse.
  - flush in the same cycle as start in IDLE: op not accepted (includes MTHI/MTLO).
  - flush has priority over the FIX-edge write.
- Simultaneous events:
  - rd_hilo in the FIX cycle: stall=1; the read sees the new values in the following cycle.
  - rd_hilo while IDLE: stall=0; hi/lo are stable and read directly.
- Reset mid-operation: immediate return to the reset values; the partial result is discarded.
- Widths: internal accumulator is 2*XLEN+1 bits for division (remainder plus sign guard). Counter width is $clog2(XLEN).

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings (MDU_NOP..MDU_MTLO)
  - state encoding (S_IDLE, S_RUN, S_FIX)
  - XLEN default
- Sub-module mdu_divstep: combinational single restoring step. Inputs are partial remainder, next dividend bit, and divisor. Outputs are the new remainder and the quotient bit. It is instantiated once; the multiply step stays inline.

Test Plan:
- MULTU x=0xFFFFFFFF, y=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001; done one cycle; busy high for exactly 33 cycles.
- MULT x=-3 (0xFFFFFFFD), y=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV x=-7, y=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU x=100, y=0 -> hi=100, lo=0xFFFFFFFF after 33 cycles. DIV x=0x80000000, y=-1 -> lo=0x80000000, hi=0.
- Start MULT 5*6, assert rd_hilo at cycle 10 -> stall=1 until busy falls; MFHI/MFLO then read hi=0, lo=30. MTLO presented at cycle 5 stalls and is applied after completion, giving lo=x.
- Flush at cycle 20 of DIVU 50/7 with prior hi=0x11, lo=0x22 -> busy drops next cycle, no done, hi/lo unchanged; a new start is accepted the cycle after that.
- Assert rst_n=0 mid-RUN, asynchronously between edges -> hi=lo=0 and busy=0 immediately; after release, MTHI x=0xABCD gives hi=0xABCD in one cycle with no busy.
